// File: rtl/axi_slv_mem.sv
// AXI slave memory: independent write and read FSMs servicing FIXED, INCR and WRAP bursts
// from a byte-enabled word array. One outstanding transaction per direction.
module axi_slv_mem #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ID_W      = 32,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  areset,
    // write address channel
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [LEN_W-1:0]      awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    // write data channel
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    // write response channel
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    // read address channel
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [LEN_W-1:0]      arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    // read data channel
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Burst-level errors: unsupported size, reserved burst type, illegal WRAP length.
    function automatic logic cfg_err(input logic [LEN_W-1:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                      (len == LEN_W'(7)) || (len == LEN_W'(15));
        return (32'(size) > OFF_W) || (burst == 2'd3) || ((burst == 2'd2) && !wrap_len_ok);
    endfunction

    function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
        return (addr >> OFF_W) >= ADDR_W'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [LEN_W-1:0]  len,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] aligned;
        logic [ADDR_W-1:0] cmask;
        step    = ADDR_W'(1) << size;
        aligned = addr & ~(step - ADDR_W'(1));
        cmask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'd1:    return aligned + step;
            // Keep the container base, let the offset roll over inside the container.
            2'd2:    return (aligned & ~cmask) | ((aligned + step) & cmask);
            default: return addr;
        endcase
    endfunction

    // ------------------------------------------------------------------ write path
    w_state_e          w_state_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [LEN_W-1:0]  aw_len_q;
    logic [2:0]        aw_size_q;
    logic [1:0]        aw_burst_q;
    logic [LEN_W-1:0]  w_cnt_q;
    logic              w_over_q;
    logic              w_err_q;
    logic              w_hs;
    logic              w_beat_err;
    logic              mem_we;

    assign w_hs       = wvalid && wready;
    // w_over_q marks beats past awlen that arrive while waiting for a late wlast.
    assign w_beat_err = cfg_err(aw_len_q, aw_size_q, aw_burst_q) || addr_err(w_addr_q) ||
                        w_over_q || (wlast && (w_cnt_q != aw_len_q));
    assign mem_we     = !areset && (w_state_q == WData) && w_hs && !w_beat_err;

    always_ff @(posedge clk) begin
        if (areset) begin
            w_state_q  <= WIdle;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= RESP_OKAY;
            aw_id_q    <= '0;
            w_addr_q   <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_over_q   <= 1'b0;
            w_err_q    <= 1'b0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    if (awvalid && awready) begin
                        aw_id_q    <= awid;
                        w_addr_q   <= awaddr;
                        aw_len_q   <= awlen;
                        aw_size_q  <= awsize;
                        aw_burst_q <= awburst;
                        w_cnt_q    <= '0;
                        w_over_q   <= 1'b0;
                        w_err_q    <= 1'b0;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        w_state_q  <= WData;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                WData: begin
                    if (w_hs) begin
                        w_addr_q <= next_addr(w_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                        if (w_cnt_q == aw_len_q) begin
                            w_over_q <= 1'b1;
                        end else begin
                            w_cnt_q <= w_cnt_q + LEN_W'(1);
                        end
                        if (w_beat_err) begin
                            w_err_q <= 1'b1;
                        end
                        if (wlast) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bid       <= aw_id_q;
                            bresp     <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready   <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    // Array is never reset so contents survive areset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------ read path
    r_state_e          r_state_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [LEN_W-1:0]  ar_len_q;
    logic [2:0]        ar_size_q;
    logic [1:0]        ar_burst_q;
    logic [LEN_W-1:0]  r_cnt_q;
    logic              ar_err;
    logic              r_err;

    assign ar_err = cfg_err(arlen, arsize, arburst) || addr_err(araddr);
    assign r_err  = cfg_err(ar_len_q, ar_size_q, ar_burst_q) || addr_err(r_addr_q);

    // r_addr_q and r_cnt_q always describe the next beat to be presented.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state_q  <= RIdle;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rid        <= '0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            r_addr_q   <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    if (arvalid && arready) begin
                        ar_len_q   <= arlen;
                        ar_size_q  <= arsize;
                        ar_burst_q <= arburst;
                        r_addr_q   <= next_addr(araddr, arlen, arsize, arburst);
                        r_cnt_q    <= LEN_W'(1);
                        rid        <= arid;
                        rvalid     <= 1'b1;
                        rlast      <= (arlen == '0);
                        rdata      <= ar_err ? '0 : mem[word_idx(araddr)];
                        rresp      <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        arready    <= 1'b0;
                        r_state_q  <= RData;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                RData: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready   <= 1'b1;
                            r_state_q <= RIdle;
                        end else begin
                            rdata    <= r_err ? '0 : mem[word_idx(r_addr_q)];
                            rresp    <= r_err ? RESP_SLVERR : RESP_OKAY;
                            rlast    <= (r_cnt_q == ar_len_q);
                            r_addr_q <= next_addr(r_addr_q, ar_len_q, ar_size_q, ar_burst_q);
                            r_cnt_q  <= r_cnt_q + LEN_W'(1);
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed bench for axi_slv_mem (DATA_W=128, AXI3 length field, 1024 words).
module tb_axi_slv_mem;
    logic clk = 1'b0;
    logic areset;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awid, awaddr, arid, araddr, bid, rid;
    logic [3:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [127:0] wdata, rdata;
    logic [15:0] wstrb;

    always #5 clk = ~clk;

    axi_slv_mem #(.DATA_W(128), .ADDR_W(32), .ID_W(32), .LEN_W(4), .MEM_DEPTH(1024)) dut (
        .clk(clk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    int total = 0;
    int bad = 0;
    logic [127:0] wbuf [16];
    logic [127:0] rbuf [32];
    logic [1:0]   rrsp [32];
    logic         rlst [32];
    logic [31:0]  rid_seen;

    task automatic do_write(input logic [31:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input logic [15:0] strb, input int b_hold, output logic [1:0] resp,
                            output logic [31:0] rsp_id, output logic w_next, output logic b_next,
                            output int b_viol);
        int t;
        b_viol = 0; resp = 2'b11; rsp_id = '0; w_next = 1'b0; b_next = 1'b0;
        bready = (b_hold == 0);
        @(negedge clk);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (!awready) begin
            total++; bad++; awvalid = 1'b0;
            $display("FAIL aw_timeout awready=%0b required=1", awready);
            return;
        end
        @(negedge clk);
        awvalid = 1'b0;
        w_next = wready;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb; wlast = (b == nbeats - 1);
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (!wready) begin
                total++; bad++; wvalid = 1'b0; wlast = 1'b0;
                $display("FAIL w_timeout beat=%0d wready=%0b required=1", b, wready);
                return;
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        b_next = bvalid;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (!bvalid) begin
            total++; bad++; bready = 1'b1;
            $display("FAIL b_timeout bvalid=%0b required=1", bvalid);
            return;
        end
        resp = bresp; rsp_id = bid;
        repeat (b_hold) begin
            @(negedge clk);
            if (!bvalid || awready || bresp !== resp || bid !== rsp_id) b_viol++;
        end
        bready = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                           input int stall_cyc, output int nb, output logic r_next,
                           output int viol);
        int t;
        logic done;
        logic [127:0] sd;
        logic [1:0] sr;
        logic sl;
        nb = 0; viol = 0; r_next = 1'b0; done = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) begin
            total++; bad++; arvalid = 1'b0;
            $display("FAIL ar_timeout arready=%0b required=1", arready);
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        r_next = rvalid;
        while (!done && nb < 32) begin
            t = 0;
            while (!rvalid && t < 50) begin @(negedge clk); t++; end
            if (!rvalid) begin
                total++; bad++;
                $display("FAIL r_timeout beat=%0d rvalid=%0b required=1", nb, rvalid);
                return;
            end
            if (nb == stall_beat && stall_cyc > 0) begin
                rready = 1'b0; sd = rdata; sr = rresp; sl = rlast;
                repeat (stall_cyc) begin
                    @(negedge clk);
                    if (!rvalid || rdata !== sd || rresp !== sr || rlast !== sl || arready) viol++;
                end
                rready = 1'b1;
            end
            rbuf[nb] = rdata; rrsp[nb] = rresp; rlst[nb] = rlast; rid_seen = rid;
            done = rlast;
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=000000",
                     {awready, arready, wready, bvalid, rvalid, rlast});
        end
        total++;
        if ({bid, bresp, rid, rresp, rdata} !== '0) begin
            bad++; $display("FAIL reset_data bid=%h rid=%h rdata=%h required=0", bid, rid, rdata);
        end
        areset = 1'b0;
        @(negedge clk);
        total++;
        if ({awready, arready} !== 2'b11) begin
            bad++; $display("FAIL reset_release_ready got=%b required=11", {awready, arready});
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        logic [127:0] exp;
        for (int k = 0; k < 4; k++) wbuf[k] = {4{32'hA000_0000 | 32'(k)}};
        do_write(32'h11, 32'h40, 4'd3, 3'd4, 2'd1, 4, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        total++; if (wn !== 1'b1) begin bad++; $display("FAIL incr_wready_n1 got=%0b required=1", wn); end
        total++; if (bn !== 1'b1) begin bad++; $display("FAIL incr_bvalid_m1 got=%0b required=1", bn); end
        total++; if (resp !== 2'd0) begin bad++; $display("FAIL incr_bresp got=%0d required=0", resp); end
        total++; if (bidv !== 32'h11) begin bad++; $display("FAIL incr_bid got=%h required=11", bidv); end
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL incr_awready_after_b got=%0b required=1", awready); end
        do_read(32'h22, 32'h40, 4'd3, 3'd4, 2'd1, -1, 0, nb, rn, viol);
        total++; if (rn !== 1'b1) begin bad++; $display("FAIL incr_rvalid_n1 got=%0b required=1", rn); end
        total++; if (nb !== 4) begin bad++; $display("FAIL incr_beats got=%0d required=4", nb); end
        for (int k = 0; k < 4; k++) begin
            exp = {4{32'hA000_0000 | 32'(k)}};
            total++;
            if (rbuf[k] !== exp || rrsp[k] !== 2'd0 || rlst[k] !== (k == 3)) begin
                bad++;
                $display("FAIL incr_beat%0d got=%h/%0d/%0b required=%h/0/%0b", k, rbuf[k], rrsp[k],
                         rlst[k], exp, (k == 3));
            end
        end
        total++; if (rid_seen !== 32'h22) begin bad++; $display("FAIL incr_rid got=%h required=22", rid_seen); end
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL incr_arready_after got=%0b required=1", arready); end
    endtask

    task automatic test_wrap();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        logic [127:0] exp;
        int ord [4] = '{3, 0, 1, 2};
        for (int k = 0; k < 4; k++) wbuf[k] = {4{32'hC000_0000 | 32'(k)}};
        do_write(32'h1, 32'h0, 4'd3, 3'd4, 2'd1, 4, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        do_read(32'h2, 32'h30, 4'd3, 3'd4, 2'd2, -1, 0, nb, rn, viol);
        total++; if (nb !== 4) begin bad++; $display("FAIL wrap_beats got=%0d required=4", nb); end
        for (int k = 0; k < 4; k++) begin
            exp = {4{32'hC000_0000 | 32'(ord[k])}};
            total++;
            if (rbuf[k] !== exp || rrsp[k] !== 2'd0 || rlst[k] !== (k == 3)) begin
                bad++;
                $display("FAIL wrap_beat%0d got=%h/%0d/%0b required=%h/0/%0b", k, rbuf[k], rrsp[k],
                         rlst[k], exp, (k == 3));
            end
        end
        do_read(32'h3, 32'h0, 4'd2, 3'd4, 2'd2, -1, 0, nb, rn, viol);
        total++; if (nb !== 3) begin bad++; $display("FAIL wrap_len2_beats got=%0d required=3", nb); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rbuf[k] !== '0 || rrsp[k] !== 2'd2) begin
                bad++;
                $display("FAIL wrap_len2_beat%0d got=%h/%0d required=0/2", k, rbuf[k], rrsp[k]);
            end
        end
    endtask

    task automatic test_narrow();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        wbuf[0] = '0;
        do_write(32'h5, 32'h200, 4'd0, 3'd4, 2'd1, 1, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        wbuf[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_DEAD_BEEF;
        do_write(32'h6, 32'h200, 4'd0, 3'd4, 2'd1, 1, 16'h0003, 0, resp, bidv, wn, bn, bv);
        total++; if (resp !== 2'd0) begin bad++; $display("FAIL narrow_bresp got=%0d required=0", resp); end
        do_read(32'h7, 32'h200, 4'd0, 3'd4, 2'd1, -1, 0, nb, rn, viol);
        total++;
        if (rbuf[0] !== 128'h0000_BEEF || rlst[0] !== 1'b1) begin
            bad++; $display("FAIL narrow_data got=%h/%0b required=beef/1", rbuf[0], rlst[0]);
        end
    endtask

    task automatic test_fixed();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        for (int k = 0; k < 3; k++) wbuf[k] = {4{32'hF000_0000 | 32'(k)}};
        do_write(32'h8, 32'h500, 4'd2, 3'd4, 2'd0, 3, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        do_read(32'h9, 32'h500, 4'd2, 3'd4, 2'd0, -1, 0, nb, rn, viol);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rbuf[k] !== {4{32'hF000_0002}}) begin
                bad++; $display("FAIL fixed_beat%0d got=%h required=%h", k, rbuf[k], {4{32'hF000_0002}});
            end
        end
    endtask

    task automatic test_wlast_err();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        logic [127:0] exp;
        for (int k = 0; k < 6; k++) wbuf[k] = {4{32'h5000_0000 | 32'(k)}};
        do_write(32'h30, 32'h300, 4'd3, 3'd4, 2'd1, 4, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        do_write(32'h31, 32'h400, 4'd5, 3'd4, 2'd1, 6, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        for (int k = 0; k < 6; k++) wbuf[k] = {4{32'hE000_0000 | 32'(k)}};
        do_write(32'h33, 32'h300, 4'd3, 3'd4, 2'd1, 2, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        total++; if (resp !== 2'd2) begin bad++; $display("FAIL early_wlast_bresp got=%0d required=2", resp); end
        do_read(32'h34, 32'h300, 4'd1, 3'd4, 2'd1, -1, 0, nb, rn, viol);
        total++;
        if (rbuf[0] !== {4{32'hE000_0000}} || rbuf[1] !== {4{32'h5000_0001}}) begin
            bad++; $display("FAIL early_wlast_mem got=%h,%h required=e0,p1", rbuf[0], rbuf[1]);
        end
        for (int k = 0; k < 6; k++) wbuf[k] = {4{32'hB000_0000 | 32'(k)}};
        do_write(32'h35, 32'h400, 4'd3, 3'd4, 2'd1, 6, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        total++; if (resp !== 2'd2) begin bad++; $display("FAIL late_wlast_bresp got=%0d required=2", resp); end
        do_read(32'h36, 32'h400, 4'd5, 3'd4, 2'd1, -1, 0, nb, rn, viol);
        for (int k = 0; k < 6; k++) begin
            exp = (k < 4) ? {4{32'hB000_0000 | 32'(k)}} : {4{32'h5000_0000 | 32'(k)}};
            total++;
            if (rbuf[k] !== exp) begin
                bad++; $display("FAIL late_wlast_word%0d got=%h required=%h", k, rbuf[k], exp);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        do_read(32'h40, 32'h0, 4'd0, 3'd5, 2'd1, -1, 0, nb, rn, viol);
        total++;
        if (rrsp[0] !== 2'd2 || rbuf[0] !== '0) begin
            bad++; $display("FAIL err_size got=%0d/%h required=2/0", rrsp[0], rbuf[0]);
        end
        do_read(32'h41, 32'h0, 4'd0, 3'd4, 2'd3, -1, 0, nb, rn, viol);
        total++; if (rrsp[0] !== 2'd2) begin bad++; $display("FAIL err_burst3 got=%0d required=2", rrsp[0]); end
        do_read(32'h42, 32'h3FF0, 4'd1, 3'd4, 2'd1, -1, 0, nb, rn, viol);
        total++;
        if (rrsp[0] !== 2'd0 || rrsp[1] !== 2'd2 || rbuf[1] !== '0) begin
            bad++; $display("FAIL err_range got=%0d,%0d/%h required=0,2/0", rrsp[0], rrsp[1], rbuf[1]);
        end
        wbuf[0] = '1;
        do_write(32'h43, 32'h4000, 4'd0, 3'd4, 2'd1, 1, 16'hFFFF, 0, resp, bidv, wn, bn, bv);
        total++; if (resp !== 2'd2) begin bad++; $display("FAIL err_wr_range got=%0d required=2", resp); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [31:0] bidv; logic wn, bn, rn; int bv, nb, viol;
        do_read(32'h50, 32'h40, 4'd3, 3'd4, 2'd1, 1, 3, nb, rn, viol);
        total++; if (viol !== 0) begin bad++; $display("FAIL rstall_stable got=%0d required=0", viol); end
        total++;
        if (nb !== 4 || rbuf[1] !== {4{32'hA000_0001}} || rlst[3] !== 1'b1) begin
            bad++; $display("FAIL rstall_data nb=%0d got=%h required=%h", nb, rbuf[1], {4{32'hA000_0001}});
        end
        wbuf[0] = {4{32'h1234_5678}};
        do_write(32'h51, 32'h600, 4'd0, 3'd4, 2'd1, 1, 16'hFFFF, 5, resp, bidv, wn, bn, bv);
        total++; if (bv !== 0) begin bad++; $display("FAIL bstall_stable got=%0d required=0", bv); end
        total++;
        if (resp !== 2'd0 || bidv !== 32'h51) begin
            bad++; $display("FAIL bstall_resp got=%0d/%h required=0/51", resp, bidv);
        end
    endtask

    task automatic test_reset_mid();
        int t, nb, viol; logic rn; logic [127:0] exp;
        rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b1; arid = 32'h60; araddr = 32'h40; arlen = 4'd3; arsize = 3'd4; arburst = 2'd1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 ||
            {bid, bresp, rid, rresp, rdata} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs ctrl=%b rid=%h rdata=%h required=0",
                     {awready, arready, wready, bvalid, rvalid, rlast}, rid, rdata);
        end
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        total++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            bad++; $display("FAIL midreset_release arready=%0b rvalid=%0b required=1/0", arready, rvalid);
        end
        do_read(32'h61, 32'h40, 4'd3, 3'd4, 2'd1, -1, 0, nb, rn, viol);
        for (int k = 0; k < 4; k++) begin
            exp = {4{32'hA000_0000 | 32'(k)}};
            total++;
            if (rbuf[k] !== exp) begin
                bad++; $display("FAIL midreset_keep%0d got=%h required=%h", k, rbuf[k], exp);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1;
        test_reset();
        test_incr();
        test_wrap();
        test_narrow();
        test_fixed();
        test_wlast_err();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end

endmodule
